hack_cpu_sequencer: RTL

- Multi-cycle control sequencer for the Hack CPU datapath.
- Fetches 16-bit instructions over a req/ack port and decodes A- and C-instructions.
- Drives the external combinational ALU (x, y, zx, nx, zy, ny, f, no) and samples out/zr/ng.
- Owns the A, D and PC registers and performs M reads and writes over a second req/ack port.

---
 rtl/hack_cpu_sequencer_if.sv | 40 ++++
 rtl/hack_cpu_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hack_cpu_sequencer_if.sv
// Bus bundle for the Hack CPU sequencer: instruction fetch port, data memory
// port and the external combinational ALU.
interface hack_cpu_sequencer_if;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic        instr_ack;
  logic [15:0] instr_data;

  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;

  modport master (
    output instr_req, instr_addr,
    input  instr_ack, instr_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output alu_x, alu_y, alu_ctrl,
    input  alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_ack, instr_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  alu_x, alu_y, alu_ctrl,
    output alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_cpu_sequencer.sv
// Multi-cycle Hack CPU control sequencer: fetch, decode, M read, execute, M write.
// Define HACK_SEQ_HALT_EN to add a HALT state entered on a taken jump-to-self.
module hack_cpu_sequencer #(
  parameter logic [14:0] RESET_PC = 15'd0
) (
  input  logic                        clk,
  input  logic                        reset,
  hack_cpu_sequencer_if.master        bus,
  output logic [14:0]                 pc,
  output logic                        halted
);

`ifdef HACK_SEQ_HALT_EN
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_READM, S_EXEC, S_WRITEM, S_HALT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_READM, S_EXEC, S_WRITEM
  } state_t;
`endif

  state_t      state, state_n;
  logic [14:0] pc_q, pc_n;
  logic [15:0] a_q, a_n;
  logic [15:0] d_q, d_n;
  logic [15:0] ir_q, ir_n;
  logic [15:0] m_q, m_n;
  logic [15:0] result_q, result_n;
  logic [14:0] wr_addr_q, wr_addr_n;
  logic        jump_taken;

  assign jump_taken = (ir_q[2] & bus.alu_ng)
                    | (ir_q[1] & bus.alu_zr)
                    | (ir_q[0] & ~bus.alu_zr & ~bus.alu_ng);

  // NOTE: every register holds its value unless the state below overrides it;
  // giving each *_n its current value first keeps this block free of latches.
  always_comb begin
    state_n   = state;
    pc_n      = pc_q;
    a_n       = a_q;
    d_n       = d_q;
    ir_n      = ir_q;
    m_n       = m_q;
    result_n  = result_q;
    wr_addr_n = wr_addr_q;
    case (state)
      S_FETCH: begin
        if (bus.instr_ack) begin
          ir_n    = bus.instr_data;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!ir_q[15]) begin
          a_n     = ir_q;
          pc_n    = pc_q + 15'd1;
          state_n = S_FETCH;
        end else if (ir_q[12]) begin
          state_n = S_READM;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_READM: begin
        if (bus.mem_ack) begin
          m_n     = bus.mem_rdata;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        // The M write address is captured from A before any A update lands.
        result_n  = bus.alu_out;
        wr_addr_n = a_q[14:0];
        if (ir_q[5]) a_n = bus.alu_out;
        if (ir_q[4]) d_n = bus.alu_out;
        pc_n    = jump_taken ? a_q[14:0] : pc_q + 15'd1;
        state_n = ir_q[3] ? S_WRITEM : S_FETCH;
`ifdef HACK_SEQ_HALT_EN
        if (jump_taken && (a_q[14:0] == pc_q)) state_n = S_HALT;
`endif
      end
      S_WRITEM: begin
        if (bus.mem_ack) state_n = S_FETCH;
      end
`ifdef HACK_SEQ_HALT_EN
      S_HALT: state_n = S_HALT;
`endif
      default: state_n = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc_q      <= RESET_PC;
      a_q       <= '0;
      d_q       <= '0;
      ir_q      <= '0;
      m_q       <= '0;
      result_q  <= '0;
      wr_addr_q <= '0;
    end else begin
      state     <= state_n;
      pc_q      <= pc_n;
      a_q       <= a_n;
      d_q       <= d_n;
      ir_q      <= ir_n;
      m_q       <= m_n;
      result_q  <= result_n;
      wr_addr_q <= wr_addr_n;
    end
  end

  // Bus controls decode purely from state, so they stay stable for a whole handshake.
  assign bus.instr_req  = (state == S_FETCH);
  assign bus.instr_addr = pc_q;
  assign bus.mem_req    = (state == S_READM) || (state == S_WRITEM);
  assign bus.mem_we     = (state == S_WRITEM);
  assign bus.mem_addr   = (state == S_WRITEM) ? wr_addr_q : a_q[14:0];
  assign bus.mem_wdata  = result_q;
  assign bus.alu_x      = d_q;
  assign bus.alu_y      = ir_q[12] ? m_q : a_q;
  assign bus.alu_ctrl   = ir_q[11:6];
  assign pc             = pc_q;

`ifdef HACK_SEQ_HALT_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
